// File: rtl/sram_resp_pkg.sv
// Shared definitions for sram_resp: MMIO window base, register offsets,
// register decode and byte-lane merge helpers.
package sram_resp_pkg;

   localparam logic [15:0] MmioBaseDefault = 16'hBFAF;

   localparam logic [15:0] OffLed    = 16'h0000;
   localparam logic [15:0] OffTimer  = 16'h0004;
   localparam logic [15:0] OffCmp    = 16'h0008;
   localparam logic [15:0] OffStatus = 16'h000C;

   localparam logic [31:0] CmpReset = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      RegNone,
      RegLed,
      RegTimer,
      RegCmp,
      RegStatus
   } mmio_reg_e;

   function automatic mmio_reg_e mmio_decode(input logic [15:0] off);
      mmio_reg_e sel;
      case (off)
         OffLed:    sel = RegLed;
         OffTimer:  sel = RegTimer;
         OffCmp:    sel = RegCmp;
         OffStatus: sel = RegStatus;
         default:   sel = RegNone;
      endcase
      return sel;
   endfunction

   function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_resp_ram.sv
// Word RAM with one registered read port and one read-first byte-write port.
// Array contents are never reset; only the read registers are.
module sram_resp_ram #(
   parameter int unsigned MEM_AW = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [MEM_AW-1:0] rd_addr,
   output logic [31:0]       rd_data,
   input  logic              rw_en,
   input  logic [3:0]        rw_be,
   input  logic [MEM_AW-1:0] rw_addr,
   input  logic [31:0]       rw_wdata,
   output logic [31:0]       rw_rdata
);

   logic [31:0] mem [2**MEM_AW];

   always_ff @(posedge clk) begin
      if (rw_en) begin
         for (int i = 0; i < 4; i++) begin
            if (rw_be[i]) mem[rw_addr][8*i +: 8] <= rw_wdata[8*i +: 8];
         end
      end
   end

   // Both reads sample the array before this edge's write lands.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data  <= '0;
         rw_rdata <= '0;
      end else begin
         if (rd_en) rd_data  <= mem[rd_addr];
         if (rw_en) rw_rdata <= mem[rw_addr];
      end
   end

endmodule

// File: rtl/sram_resp.sv
// Instruction/data SRAM responder with an MMIO window holding LED, a free-running
// TIMER, a compare register and a sticky match STATUS bit.
module sram_resp
   import sram_resp_pkg::*;
#(
   parameter int unsigned MEM_AW    = 14,
   parameter logic [15:0] MMIO_BASE = MmioBaseDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_sram_en,
   input  logic [3:0]  inst_sram_wen,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   output logic        timer_int
);

   logic        d_mmio, i_mmio;
   logic        ram_d_en;
   mmio_reg_e   d_sel;
   logic        mmio_wr;
   logic [31:0] ram_i_rdata, ram_d_rdata;

   logic [15:0] led_q, led_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] cmp_q, cmp_d;
   logic        status_q, status_d;
   logic        status_clr;
   logic [31:0] led_wr;
   logic [31:0] mmio_rval;

   logic        d_mmio_q, i_mmio_q;
   logic [31:0] mmio_rdata_q;

   logic        unused_bits;
   assign unused_bits = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr, data_sram_addr};

   assign d_mmio   = (data_sram_addr[31:16] == MMIO_BASE);
   assign i_mmio   = (inst_sram_addr[31:16] == MMIO_BASE);
   assign ram_d_en = data_sram_en & ~d_mmio;
   assign d_sel    = mmio_decode(data_sram_addr[15:0]);
   assign mmio_wr  = data_sram_en & d_mmio & (|data_sram_wen);

   sram_resp_ram #(
      .MEM_AW(MEM_AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (inst_sram_en & ~i_mmio),
      .rd_addr (inst_sram_addr[MEM_AW+1:2]),
      .rd_data (ram_i_rdata),
      .rw_en   (ram_d_en),
      .rw_be   (data_sram_wen),
      .rw_addr (data_sram_addr[MEM_AW+1:2]),
      .rw_wdata(data_sram_wdata),
      .rw_rdata(ram_d_rdata)
   );

   always_comb begin
      led_d      = led_q;
      timer_d    = timer_q + 32'd1;
      cmp_d      = cmp_q;
      status_clr = 1'b0;
      led_wr     = apply_be({16'h0000, led_q}, data_sram_wdata, data_sram_wen);
      if (mmio_wr) begin
         case (d_sel)
            RegLed:    led_d      = led_wr[15:0];
            RegTimer:  timer_d    = apply_be(timer_q, data_sram_wdata, data_sram_wen);
            RegCmp:    cmp_d      = apply_be(cmp_q, data_sram_wdata, data_sram_wen);
            RegStatus: status_clr = data_sram_wen[0] & data_sram_wdata[0];
            default:   ;
         endcase
      end
      // A match in the same cycle as a W1C keeps the bit set.
      status_d = (timer_q == cmp_q) | (status_q & ~status_clr);
   end

   always_comb begin
      mmio_rval = '0;
      case (d_sel)
         RegLed:    mmio_rval = {16'h0000, led_q};
         RegTimer:  mmio_rval = timer_q;
         RegCmp:    mmio_rval = cmp_q;
         RegStatus: mmio_rval = {31'h0, status_q};
         default:   mmio_rval = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_q        <= '0;
         timer_q      <= '0;
         cmp_q        <= CmpReset;
         status_q     <= 1'b0;
         d_mmio_q     <= 1'b0;
         i_mmio_q     <= 1'b0;
         mmio_rdata_q <= '0;
      end else begin
         led_q    <= led_d;
         timer_q  <= timer_d;
         cmp_q    <= cmp_d;
         status_q <= status_d;
         if (data_sram_en) begin
            d_mmio_q     <= d_mmio;
            mmio_rdata_q <= mmio_rval;
         end
         if (inst_sram_en) i_mmio_q <= i_mmio;
      end
   end

   assign data_sram_rdata = d_mmio_q ? mmio_rdata_q : ram_d_rdata;
   assign inst_sram_rdata = i_mmio_q ? 32'h0 : ram_i_rdata;
   assign led             = led_q;
   assign timer_int       = status_q;

endmodule

// File: tb/tb_sram_resp.sv
// Scoreboard bench for sram_resp: a cycle-level reference model queues expected
// outputs per issued cycle; an independent monitor pops and compares after each edge.
module tb_sram_resp;

   localparam logic [15:0] Base = 16'hBFAF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_sram_en = 1'b0;
   logic [3:0]  inst_sram_wen = '0;
   logic [31:0] inst_sram_addr = '0;
   logic [31:0] inst_sram_wdata = '0;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en = 1'b0;
   logic [3:0]  data_sram_wen = '0;
   logic [31:0] data_sram_addr = '0;
   logic [31:0] data_sram_wdata = '0;
   logic [31:0] data_sram_rdata;
   logic [15:0] led;
   logic        timer_int;

   sram_resp dut (
      .clk            (clk),
      .rst            (rst),
      .inst_sram_en   (inst_sram_en),
      .inst_sram_wen  (inst_sram_wen),
      .inst_sram_addr (inst_sram_addr),
      .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_rdata(inst_sram_rdata),
      .data_sram_en   (data_sram_en),
      .data_sram_wen  (data_sram_wen),
      .data_sram_addr (data_sram_addr),
      .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata),
      .led            (led),
      .timer_int      (timer_int)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] drd;
      bit          dk;
      logic [31:0] ird;
      bit          ik;
      logic [15:0] led;
      logic        tint;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mem[int];
   logic [15:0] m_led;
   logic [31:0] m_cmp;
   logic        m_status;
   logic [31:0] t0_val;
   int          t0_cyc;
   int          cyc = 0;
   logic [31:0] d_last, i_last;
   bit          d_known, i_known;
   int          n_cmp = 0;
   int          n_err = 0;
   bit          mon_on = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_led    = '0;
      m_cmp    = 32'hFFFF_FFFF;
      m_status = 1'b0;
      t0_val   = '0;
      t0_cyc   = cyc;
      d_last   = '0;
      i_last   = '0;
      d_known  = 1'b1;
      i_known  = 1'b1;
      q.delete();
   endtask

   // One bus cycle: drive at negedge, predict, queue expectation, end at next negedge.
   task automatic cycle(input logic ien, input logic [31:0] iaddr, input logic den,
                        input logic [3:0] dwen, input logic [31:0] daddr,
                        input logic [31:0] dwdata);
      logic [31:0] tnow, wtmp;
      logic        match, clr;
      int          widx, iidx;
      exp_t        e;
      inst_sram_en    = ien;
      inst_sram_addr  = iaddr;
      inst_sram_wen   = 4'($urandom);
      inst_sram_wdata = $urandom;
      data_sram_en    = den;
      data_sram_wen   = dwen;
      data_sram_addr  = daddr;
      data_sram_wdata = dwdata;
      tnow  = t0_val + 32'(cyc - t0_cyc);
      match = (tnow == m_cmp);
      clr   = 1'b0;
      if (ien) begin
         if (iaddr[31:16] == Base) begin
            i_last  = '0;
            i_known = 1'b1;
         end else begin
            iidx    = int'(iaddr[15:2]);
            i_known = mem.exists(iidx);
            i_last  = i_known ? mem[iidx] : 'x;
         end
      end
      if (den) begin
         if (daddr[31:16] == Base) begin
            d_known = 1'b1;
            case (daddr[15:0])
               16'h0000: d_last = {16'h0, m_led};
               16'h0004: d_last = tnow;
               16'h0008: d_last = m_cmp;
               16'h000C: d_last = {31'h0, m_status};
               default:  d_last = '0;
            endcase
            if (dwen != 4'h0) begin
               case (daddr[15:0])
                  16'h0000: begin
                     wtmp  = merge({16'h0, m_led}, dwdata, dwen);
                     m_led = wtmp[15:0];
                  end
                  16'h0004: begin
                     t0_val = merge(tnow, dwdata, dwen);
                     t0_cyc = cyc + 1;
                  end
                  16'h0008: m_cmp = merge(m_cmp, dwdata, dwen);
                  16'h000C: clr = dwen[0] & dwdata[0];
                  default: ;
               endcase
            end
         end else begin
            widx    = int'(daddr[15:2]);
            d_known = mem.exists(widx);
            d_last  = d_known ? mem[widx] : 'x;
            if (dwen == 4'hF) mem[widx] = dwdata;
            else if (dwen != 4'h0 && d_known) mem[widx] = merge(mem[widx], dwdata, dwen);
            else if (dwen != 4'h0) mem.delete(widx);
         end
      end
      m_status = match | (m_status & ~clr);
      e.drd  = d_last;
      e.dk   = d_known;
      e.ird  = i_last;
      e.ik   = i_known;
      e.led  = m_led;
      e.tint = m_status;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic dwrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      cycle(1'b0, 32'h0, 1'b1, be, a, d);
   endtask

   task automatic dread(input logic [31:0] a);
      cycle(1'b0, 32'h0, 1'b1, 4'h0, a, 32'h0);
   endtask

   initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (mon_on) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
         end else begin
            e = q.pop_front();
            if (e.dk) check("data_rdata", data_sram_rdata, e.drd);
            if (e.ik) check("inst_rdata", inst_sram_rdata, e.ird);
            check("led", {16'h0, led}, {16'h0, e.led});
            check("timer_int", {31'h0, timer_int}, {31'h0, e.tint});
         end
      end
   end

   function automatic logic [31:0] pool_addr();
      logic [15:0] up;
      up = 16'($urandom);
      if (up == Base) up = 16'h0;
      return {up, 14'(14'h400 + 14'($urandom_range(0, 15))), 2'($urandom)};
   endfunction

   initial begin
      logic [31:0] ia, da, dw;
      logic [3:0]  be;
      logic [15:0] offs[6];
      offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0002};

      // Power-on reset
      #2;
      check("rst_inst_rdata", inst_sram_rdata, 32'h0);
      check("rst_data_rdata", data_sram_rdata, 32'h0);
      check("rst_led", {16'h0, led}, 32'h0);
      check("rst_timer_int", {31'h0, timer_int}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
      mon_on = 1'b1;

      // Byte-lane write
      dwrite(32'h0000_0100, 4'hF, 32'h1122_3344);
      dwrite(32'h0000_0100, 4'h2, 32'h0000_AA00);
      dread(32'h0000_0100);
      check("byte_lane", data_sram_rdata, 32'h1122_AA44);

      // Same-cycle inst read / data write: old word to inst
      dwrite(32'h0000_0200, 4'hF, 32'hDEAD_BEEF);
      cycle(1'b1, 32'h0000_0200, 1'b1, 4'hF, 32'h0000_0200, 32'h0);
      check("cross_old", inst_sram_rdata, 32'hDEAD_BEEF);
      cycle(1'b1, 32'h0000_0200, 1'b0, 4'h0, 32'h0, 32'h0);
      check("cross_new", inst_sram_rdata, 32'h0);

      // Match then W1C in the match cycle (set wins), later W1C clears
      dwrite({Base, 16'h0008}, 4'hF, 32'h0000_0040);
      dwrite({Base, 16'h0004}, 4'hF, 32'h0000_003E);
      idle();
      idle();
      check("pre_match_int", {31'h0, timer_int}, 32'h0);
      dwrite({Base, 16'h000C}, 4'h1, 32'h0000_0001);
      check("match_set_wins", {31'h0, timer_int}, 32'h1);
      idle();
      check("match_holds", {31'h0, timer_int}, 32'h1);
      dwrite({Base, 16'h000C}, 4'h1, 32'h0000_0001);
      check("w1c_clears", {31'h0, timer_int}, 32'h0);

      // Timer wrap
      dwrite({Base, 16'h0004}, 4'hF, 32'hFFFF_FFFE);
      idle();
      idle();
      dread({Base, 16'h0004});
      check("timer_wrap", data_sram_rdata, 32'h0);

      // MMIO edges
      dwrite({Base, 16'h0000}, 4'hF, 32'h0000_1234);
      cycle(1'b1, {Base, 16'h0000}, 1'b1, 4'h0, {Base, 16'h0010}, 32'h0);
      check("unmapped_read", data_sram_rdata, 32'h0);
      check("inst_mmio_read", inst_sram_rdata, 32'h0);
      check("led_value", {16'h0, led}, 32'h0000_1234);

      // Populate the random pool
      for (int i = 0; i < 16; i++) dwrite({16'h0, 14'(14'h400 + 14'(i)), 2'b00}, 4'hF, $urandom);

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) ia = {Base, 16'($urandom)};
         else ia = pool_addr();
         be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         dw = $urandom;
         if ($urandom_range(0, 3) == 0) da = {Base, offs[$urandom_range(0, 5)]};
         else da = pool_addr();
         cycle($urandom_range(0, 3) != 0, ia, $urandom_range(0, 3) != 0, be, da, dw);
      end

      // Mid-run reset with an access in flight
      dwrite({Base, 16'h0000}, 4'hF, 32'h0000_BEEF);
      mon_on = 1'b0;
      q.delete();
      data_sram_en   = 1'b1;
      data_sram_wen  = 4'h0;
      data_sram_addr = 32'h0000_0100;
      inst_sram_en   = 1'b1;
      inst_sram_addr = 32'h0000_0100;
      #2;
      rst = 1'b0;
      #1;
      check("midrst_led", {16'h0, led}, 32'h0);
      check("midrst_data_rdata", data_sram_rdata, 32'h0);
      check("midrst_inst_rdata", inst_sram_rdata, 32'h0);
      check("midrst_timer_int", {31'h0, timer_int}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      mon_on = 1'b1;
      idle();
      check("post_rst_hold", data_sram_rdata, 32'h0);
      dread({Base, 16'h0008});
      check("post_rst_cmp", data_sram_rdata, 32'hFFFF_FFFF);
      dread(32'h0000_0100);
      check("ram_retained", data_sram_rdata, 32'h1122_AA44);
      for (int n = 0; n < 8; n++) cycle(1'b1, pool_addr(), 1'b1, 4'h0, pool_addr(), 32'h0);

      mon_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sram_resp.md
SRAM_RESP -- requirements
Module: sram_resp

Interface
REQ-001 SHALL have parameter MEM_AW, default 14, meaning RAM word-address width (2^MEM_AW 32-bit words).
REQ-002 SHALL have parameter MMIO_BASE, default 16'hBFAF, meaning the addr[31:16] value that selects the MMIO window.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  the reset; asynchronous, active-low.
REQ-005 SHALL have ports inst_sram_en in 1, inst_sram_wen in 4, inst_sram_addr in 32, inst_sram_wdata in 32: the instruction request.
REQ-006 SHALL have port inst_sram_rdata  out  32  the instruction read data.
REQ-007 SHALL have ports data_sram_en in 1, data_sram_wen in 4, data_sram_addr in 32, data_sram_wdata in 32: the data request.
REQ-008 SHALL have port data_sram_rdata  out  32  the data read data.
REQ-009 SHALL have port led  out  16  the LED register value.
REQ-010 SHALL have port timer_int  out  1  the timer-match interrupt level, equal to STATUS[0].

Function
REQ-011 RAM word index SHALL be addr[MEM_AW+1:2]; upper address bits are ignored outside the MMIO window.
REQ-012 Read latency SHALL be exactly 1 cycle: rdata updates on the edge after a cycle with en=1, and holds its value while en=0.
REQ-013 The data port SHALL write byte lane i (bits 8i+7:8i) when en=1 and wen[i]=1; with wen=0 the access is a read.
REQ-014 A data write cycle SHALL also return the pre-write word on data_sram_rdata (read-first).
REQ-015 The inst port SHALL be read-only; inst_sram_wen and inst_sram_wdata are ignored.
REQ-016 An inst read and a data write to the same word in the same cycle SHALL return the old word on inst_sram_rdata.
REQ-017 An access is MMIO when data_sram_addr[31:16]==MMIO_BASE; offset is addr[15:0]; MMIO accesses SHALL NOT touch RAM.
REQ-018 LED at offset 0x0000 SHALL be read/write; bits [15:0] are stored, and [31:16] read 0.
REQ-019 TIMER at 0x0004 SHALL be a 32-bit counter that increments every cycle and wraps from 0xFFFFFFFF to 0.
REQ-020 A write to TIMER SHALL load the written value, which wins over the increment; counting resumes on the next cycle.
REQ-021 CMP at 0x0008 SHALL be read/write.
REQ-022 STATUS[0] at 0x000C SHALL be set when TIMER==CMP and cleared by writing 1 to bit 0; if set and clear occur in the same cycle, set wins.
REQ-023 MMIO writes SHALL honour wen byte lanes.
REQ-024 Unmapped MMIO offsets SHALL read 0, and writes to them are ignored.
REQ-025 MMIO reads SHALL return the register value sampled in the request cycle, with the same 1-cycle latency.
REQ-026 Inst-port reads that hit the MMIO window SHALL return 0.

Reset
REQ-027 While rst=0, the outputs SHALL be: inst_sram_rdata=0, data_sram_rdata=0, led=0, timer_int=0.
REQ-028 While rst=0, the registers SHALL be: TIMER=0, CMP=0xFFFFFFFF, STATUS=0.
REQ-029 RAM contents SHALL NOT be reset.
REQ-030 An access in flight at reset assertion SHALL be discarded, and rdata SHALL read 0 until the first post-reset read.

Structure
REQ-031 The MMIO base and offsets (LED, TIMER, CMP, STATUS) SHALL be defined in the shared defines file.
REQ-032 The RAM SHALL be one sub-module, sram_resp_ram: one read port, one read-first byte-write port, and MEM_AW as its parameter.
REQ-033 The MMIO decode, registers and read muxing SHALL live in sram_resp.

Verification
REQ-034 Scenario, data port: write 0x11223344 with wen=F to 0x100, then wen=2 with data 0x0000AA00 → a read of 0x100 returns 0x1122AA44 one cycle later.
REQ-035 Scenario, cross-port: the word at 0x200 holds 0xDEADBEEF; in the same cycle, data writes 0x0 and inst reads 0x200 → inst_rdata=0xDEADBEEF, and the next inst read returns 0x0.
REQ-036 Scenario, timer wrap: write TIMER=0xFFFFFFFE, then read it 3 cycles later → value wraps through 0 and matches the count exactly.
REQ-037 Scenario, match and clear: with CMP=0x40 and TIMER=0x3E, timer_int rises when TIMER reaches 0x40 → W1C to STATUS in the match cycle leaves it 1, and a later W1C clears it.
REQ-038 Scenario, mid-run reset: set LED=0xBEEF and drop rst mid-run → led=0, rdata=0 and CMP=0xFFFFFFFF immediately, with no clock needed, and RAM still holds data written before reset.
REQ-039 Scenario, MMIO edges: data read of 0xBFAF0010 returns 0, and inst read of 0xBFAF0000 returns 0 while LED=0x1234.
